// File: rtl/mips_core_mc.sv
// Multi-cycle MIPS subset core: one FSM steps FETCH/DECODE/EXEC/MEM/WB over a single req/ready memory port.
// Zero-wait latency: branch/jump 3, ALU 4, store 4, load 5 cycles; every memory wait cycle stalls the FSM in place.
module mips_core_mc #(
    parameter logic [31:0] RESET_PC     = 32'h0000_0000,
    parameter int          ADDR_W       = 32,
    parameter bit          HAS_BYTE_OPS = 1'b1,
    parameter int          INSTRET_W    = 32
) (
    input  logic                 clk,
    input  logic                 reset,
    output logic                 mem_req,
    output logic                 mem_we,
    output logic [ADDR_W-1:0]    mem_addr,
    output logic [3:0]           mem_be,
    output logic [31:0]          mem_wdata,
    input  logic [31:0]          mem_rdata,
    input  logic                 mem_ready,
    output logic [ADDR_W-1:0]    inst_addr,
    output logic                 halted,
    output logic                 illegal,
    output logic                 retire,
    output logic [INSTRET_W-1:0] instret
);
    localparam logic [2:0] S_FETCH  = 3'd0;
    localparam logic [2:0] S_DECODE = 3'd1;
    localparam logic [2:0] S_EXEC   = 3'd2;
    localparam logic [2:0] S_MEM    = 3'd3;
    localparam logic [2:0] S_WB     = 3'd4;
    localparam logic [2:0] S_HALT   = 3'd5;

    logic [2:0]        state;
    logic [ADDR_W-1:0] pc;
    logic [31:0]       ir, a, b, alu_out, mdr;
    logic [31:0]       regs [32];
    logic              go;

    logic [5:0]  op, funct;
    logic [4:0]  rs, rt, rd, shamt;
    logic [15:0] imm;
    logic [31:0] sext_imm, zext_imm, pc_ext, pc4, branch_tgt, jump_tgt;

    assign op       = ir[31:26];
    assign rs       = ir[25:21];
    assign rt       = ir[20:16];
    assign rd       = ir[15:11];
    assign shamt    = ir[10:6];
    assign funct    = ir[5:0];
    assign imm      = ir[15:0];
    assign sext_imm = {{16{imm[15]}}, imm};
    assign zext_imm = {16'h0000, imm};
    assign pc_ext   = 32'(pc);
    assign pc4      = pc_ext + 32'd4;
    assign branch_tgt = pc4 + (sext_imm << 2);
    assign jump_tgt = {pc4[31:28], ir[25:0], 2'b00};

    logic is_r, is_syscall, is_jr, is_beq, is_bne, is_j, is_jal;
    logic is_lw, is_sw, is_lb, is_sb, is_load, is_store, is_mem, is_ctrl, byte_op;
    logic legal, misalign, accept, taken;

    assign is_r       = (op == 6'h00);
    assign is_syscall = is_r && (funct == 6'h0C);
    assign is_jr      = is_r && (funct == 6'h08);
    assign is_beq     = (op == 6'h04);
    assign is_bne     = (op == 6'h05);
    assign is_j       = (op == 6'h02);
    assign is_jal     = (op == 6'h03);
    assign is_lw      = (op == 6'h23);
    assign is_sw      = (op == 6'h2B);
    assign is_lb      = HAS_BYTE_OPS && (op == 6'h20);
    assign is_sb      = HAS_BYTE_OPS && (op == 6'h28);
    assign is_load    = is_lw || is_lb;
    assign is_store   = is_sw || is_sb;
    assign is_mem     = is_load || is_store;
    assign byte_op    = is_lb || is_sb;
    assign is_ctrl    = is_beq || is_bne || is_j || is_jal || is_jr;
    assign taken      = is_beq ? (a == b) : (a != b);
    assign misalign   = (is_lw || is_sw) && (alu_out[1:0] != 2'b00);

    always_comb begin
        legal = 1'b0;
        if (is_r) begin
            case (funct)
                6'h20, 6'h21, 6'h22, 6'h24, 6'h25, 6'h2A, 6'h00, 6'h08, 6'h0C: legal = 1'b1;
                default: legal = 1'b0;
            endcase
        end else begin
            case (op)
                6'h08, 6'h09, 6'h0C, 6'h0D, 6'h0F, 6'h04, 6'h05,
                6'h02, 6'h03, 6'h23, 6'h2B: legal = 1'b1;
                6'h20, 6'h28: legal = HAS_BYTE_OPS;
                default: legal = 1'b0;
            endcase
        end
    end

    logic [31:0] alu_res;
    always_comb begin
        alu_res = 32'd0;
        if (is_r) begin
            case (funct)
                6'h20, 6'h21: alu_res = a + b;
                6'h22:        alu_res = a - b;
                6'h24:        alu_res = a & b;
                6'h25:        alu_res = a | b;
                6'h2A:        alu_res = {31'd0, $signed(a) < $signed(b)};
                6'h00:        alu_res = b << shamt;
                default:      alu_res = 32'd0;
            endcase
        end else begin
            case (op)
                6'h0C:   alu_res = a & zext_imm;
                6'h0D:   alu_res = a | zext_imm;
                6'h0F:   alu_res = {imm, 16'h0000};
                default: alu_res = a + sext_imm;
            endcase
        end
    end

    // Lane 0 is the most significant byte (big-endian).
    logic [7:0] lane_byte;
    always_comb begin
        case (alu_out[1:0])
            2'd0:    lane_byte = mem_rdata[31:24];
            2'd1:    lane_byte = mem_rdata[23:16];
            2'd2:    lane_byte = mem_rdata[15:8];
            default: lane_byte = mem_rdata[7:0];
        endcase
    end

    // go holds the request low for one cycle after reset so a dropped transfer is visibly abandoned.
    assign mem_req   = go && ((state == S_FETCH) || (state == S_MEM && !misalign));
    assign mem_we    = (state == S_MEM) && is_store && !misalign;
    assign mem_addr  = (state == S_MEM) ? {alu_out[ADDR_W-1:2], 2'b00} : {pc[ADDR_W-1:2], 2'b00};
    assign mem_be    = (state == S_MEM && byte_op) ? (4'b1000 >> alu_out[1:0]) : 4'hF;
    assign mem_wdata = (state != S_MEM) ? 32'd0 : (is_sb ? {4{b[7:0]}} : b);
    assign accept    = mem_req && mem_ready;
    assign retire    = (state == S_DECODE && is_syscall) || (state == S_EXEC && is_ctrl) ||
                       (state == S_MEM && is_store && accept) || (state == S_WB);
    assign halted    = (state == S_HALT);
    assign inst_addr = pc;

    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= S_FETCH;
            pc      <= RESET_PC[ADDR_W-1:0];
            go      <= 1'b0;
            illegal <= 1'b0;
            instret <= '0;
            ir      <= '0;
            a       <= '0;
            b       <= '0;
            alu_out <= '0;
            mdr     <= '0;
            for (int i = 0; i < 32; i++) regs[i] <= '0;
        end else begin
            go <= 1'b1;
            if (retire) instret <= instret + INSTRET_W'(1);
            case (state)
                S_FETCH: begin
                    if (accept) begin
                        ir    <= mem_rdata;
                        state <= S_DECODE;
                    end
                end
                S_DECODE: begin
                    a <= regs[rs];
                    b <= regs[rt];
                    if (!legal) begin
                        illegal <= 1'b1;
                        state   <= S_HALT;
                    end else if (is_syscall) begin
                        state <= S_HALT;
                    end else begin
                        state <= S_EXEC;
                    end
                end
                S_EXEC: begin
                    alu_out <= alu_res;
                    if (is_ctrl) begin
                        state <= S_FETCH;
                        if (is_jr)                    pc <= ADDR_W'(a);
                        else if (is_j || is_jal)      pc <= ADDR_W'(jump_tgt);
                        else if (taken)               pc <= ADDR_W'(branch_tgt);
                        else                          pc <= ADDR_W'(pc4);
                        if (is_jal) regs[31] <= pc4;
                    end else if (is_mem) begin
                        state <= S_MEM;
                    end else begin
                        state <= S_WB;
                    end
                end
                S_MEM: begin
                    if (misalign) begin
                        illegal <= 1'b1;
                        state   <= S_HALT;
                    end else if (accept) begin
                        if (is_store) begin
                            pc    <= ADDR_W'(pc4);
                            state <= S_FETCH;
                        end else begin
                            mdr   <= is_lb ? {{24{lane_byte[7]}}, lane_byte} : mem_rdata;
                            state <= S_WB;
                        end
                    end
                end
                S_WB: begin
                    if ((is_r ? rd : rt) != 5'd0) regs[is_r ? rd : rt] <= is_load ? mdr : alu_out;
                    pc    <= ADDR_W'(pc4);
                    state <= S_FETCH;
                end
                default: state <= S_HALT;
            endcase
        end
    end
endmodule

// File: tb/tb_mips_core_mc.sv
// Directed bench for mips_core_mc: table of single-instruction programs plus hand sequences for latency, byte lanes, branches, traps and reset.
module tb_mips_core_mc;
    localparam logic [31:0] RPC     = 32'h0000_0100;
    localparam logic [31:0] SYSCALL = 32'h0000_000C;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        mem_req, mem_we;
    logic [31:0] mem_addr, mem_wdata;
    logic [3:0]  mem_be;
    logic [31:0] mem_rdata = '0;
    logic        mem_ready = 1'b1;
    logic [31:0] inst_addr;
    logic        halted, illegal, retire;
    logic [31:0] instret;

    mips_core_mc #(.RESET_PC(RPC), .ADDR_W(32), .HAS_BYTE_OPS(1'b1), .INSTRET_W(32)) dut (
        .clk(clk), .reset(reset), .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_be(mem_be), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ready(mem_ready),
        .inst_addr(inst_addr), .halted(halted), .illegal(illegal), .retire(retire), .instret(instret)
    );

    always #5 clk = ~clk;

    int n_tests = 0, n_fail = 0, cycle = 0, hold = 0, retire_cnt = 0, n_data = 0;
    bit hold_we_only = 1'b0;
    logic [31:0] mem [256];
    logic [31:0] prog [16];
    logic [31:0] d_addr [16];
    logic [31:0] d_wd [16];
    logic [3:0]  d_be [16];
    logic        d_we [16];

    typedef struct {
        string       name;
        logic [31:0] instr;
        int          dest;
        logic [31:0] exp;
    } vec_t;
    vec_t vecs [16];

    function automatic logic [31:0] enc_r(int rs, int rt, int rd, int sh, logic [5:0] fn);
        return {6'h00, 5'(rs), 5'(rt), 5'(rd), 5'(sh), fn};
    endfunction

    function automatic logic [31:0] enc_i(logic [5:0] op, int rs, int rt, logic [15:0] imm);
        return {op, 5'(rs), 5'(rt), imm};
    endfunction

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, got, exp);
        end
    endtask

    // One clock: memory model responds at the negedge, transfer takes effect at the posedge.
    task automatic tick();
        int idx;
        if (mem_req === 1'b1 && hold > 0 && (!hold_we_only || mem_we === 1'b1)) begin
            mem_ready = 1'b0;
            hold--;
        end else begin
            mem_ready = 1'b1;
        end
        idx = int'(mem_addr[9:2]);
        mem_rdata = mem_ready ? mem[idx] : 32'hFC00_0000;
        if (retire === 1'b1 && !reset) retire_cnt++;
        if (mem_req === 1'b1 && mem_ready && !reset) begin
            if (mem_addr < RPC && n_data < 16) begin
                d_addr[n_data] = mem_addr;
                d_we[n_data]   = mem_we;
                d_be[n_data]   = mem_be;
                d_wd[n_data]   = mem_wdata;
                n_data++;
            end
            if (mem_we === 1'b1)
                for (int l = 0; l < 4; l++)
                    if (mem_be[3-l]) mem[idx][31-8*l -: 8] = mem_wdata[31-8*l -: 8];
        end
        @(posedge clk);
        @(negedge clk);
        cycle++;
    endtask

    task automatic load_prog(input int n);
        for (int i = 0; i < 256; i++) mem[i] = '0;
        for (int i = 0; i < n; i++) mem[64+i] = prog[i];
        mem[32] = 32'hDEAD_BEEF;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        n_data = 0;
        retire_cnt = 0;
    endtask

    task automatic run_until_halt(input string name, input int bound);
        int k = 0;
        while (halted !== 1'b1 && k < bound) begin
            tick();
            k++;
        end
        check({name, " halt reached"}, halted, 1);
    endtask

    task automatic wait_retire(output int t);
        int k = 0;
        while (retire !== 1'b1 && k < 40) begin
            tick();
            k++;
        end
        check("retire seen", retire, 1);
        t = cycle;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int start, t0, t1, t2, k;
        bit saw;

        vecs[0]  = '{"add",   enc_r(1, 2, 3, 0, 6'h20), 3, 32'h0000_0002};
        vecs[1]  = '{"addu",  enc_r(2, 2, 3, 0, 6'h21), 3, 32'hFFFF_FFFA};
        vecs[2]  = '{"sub",   enc_r(1, 2, 3, 0, 6'h22), 3, 32'h0000_0008};
        vecs[3]  = '{"subwr", enc_r(0, 1, 3, 0, 6'h22), 3, 32'hFFFF_FFFB};
        vecs[4]  = '{"and",   enc_r(6, 2, 3, 0, 6'h24), 3, 32'h1234_5678};
        vecs[5]  = '{"or",    enc_r(6, 1, 3, 0, 6'h25), 3, 32'h1234_567D};
        vecs[6]  = '{"slt1",  enc_r(2, 1, 3, 0, 6'h2A), 3, 32'h0000_0001};
        vecs[7]  = '{"slt0",  enc_r(1, 2, 3, 0, 6'h2A), 3, 32'h0000_0000};
        vecs[8]  = '{"sll",   enc_r(0, 1, 3, 4, 6'h00), 3, 32'h0000_0050};
        vecs[9]  = '{"addi",  enc_i(6'h08, 2, 3, 16'hFFFF), 3, 32'hFFFF_FFFC};
        vecs[10] = '{"addiu", enc_i(6'h09, 1, 3, 16'h7FFF), 3, 32'h0000_8004};
        vecs[11] = '{"andi",  enc_i(6'h0C, 6, 3, 16'hFF00), 3, 32'h0000_5600};
        vecs[12] = '{"ori",   enc_i(6'h0D, 0, 3, 16'h8000), 3, 32'h0000_8000};
        vecs[13] = '{"lui",   enc_i(6'h0F, 0, 3, 16'hABCD), 3, 32'hABCD_0000};
        vecs[14] = '{"r0wr",  enc_r(1, 1, 0, 0, 6'h20), 0, 32'h0000_0000};
        vecs[15] = '{"jal",   {6'h03, 26'h45}, 31, 32'h0000_0114};

        @(negedge clk);

        // Basic program, reset state and syscall latency
        prog[0] = enc_i(6'h08, 0, 1, 16'd5);
        prog[1] = enc_i(6'h08, 0, 2, 16'hFFFD);
        prog[2] = enc_r(1, 2, 3, 0, 6'h20);
        prog[3] = SYSCALL;
        load_prog(4);
        do_reset();
        check("rst mem_req", mem_req, 0);
        check("rst mem_we", mem_we, 0);
        check("rst halted", halted, 0);
        check("rst illegal", illegal, 0);
        check("rst retire", retire, 0);
        check("rst instret", instret, 0);
        check("rst pc", inst_addr, RPC);
        tick();
        check("first req", mem_req, 1);
        check("first addr", mem_addr, RPC);
        start = cycle;
        run_until_halt("basic", 100);
        check("basic cycles", 32'(cycle - start), 14);
        check("basic instret", instret, 4);
        check("basic retires", 32'(retire_cnt), 4);
        check("basic illegal", illegal, 0);

        // Fetch held off for three cycles
        hold = 3;
        hold_we_only = 1'b0;
        do_reset();
        tick();
        start = cycle;
        for (int i = 0; i < 4; i++) begin
            check("fetch hold stable", 32'(mem_req === 1'b1 && mem_addr == RPC), 1);
            tick();
        end
        check("fetch released", mem_req, 0);
        run_until_halt("wait", 100);
        check("wait cycles", 32'(cycle - start), 17);
        check("wait instret", instret, 4);

        // Table of single-instruction programs, result stored to 0x80
        for (int v = 0; v < 16; v++) begin
            prog[0] = enc_i(6'h08, 0, 1, 16'd5);
            prog[1] = enc_i(6'h08, 0, 2, 16'hFFFD);
            prog[2] = enc_i(6'h0F, 0, 6, 16'h1234);
            prog[3] = enc_i(6'h0D, 6, 6, 16'h5678);
            prog[4] = vecs[v].instr;
            prog[5] = enc_i(6'h2B, 0, vecs[v].dest, 16'h0080);
            prog[6] = SYSCALL;
            load_prog(7);
            do_reset();
            run_until_halt(vecs[v].name, 300);
            check(vecs[v].name, mem[32], vecs[v].exp);
            check({vecs[v].name, " instret"}, instret, 7);
        end

        // Byte lanes
        prog[0] = enc_i(6'h0F, 0, 6, 16'h1234);
        prog[1] = enc_i(6'h0D, 6, 6, 16'h5678);
        prog[2] = enc_i(6'h08, 0, 7, 16'hFFFF);
        prog[3] = enc_i(6'h2B, 0, 6, 16'h0040);
        prog[4] = enc_i(6'h20, 0, 4, 16'h0041);
        prog[5] = enc_i(6'h28, 0, 7, 16'h0043);
        prog[6] = enc_i(6'h20, 0, 5, 16'h0043);
        prog[7] = enc_i(6'h2B, 0, 4, 16'h0080);
        prog[8] = enc_i(6'h2B, 0, 5, 16'h0084);
        prog[9] = SYSCALL;
        load_prog(10);
        do_reset();
        tick();
        start = cycle;
        run_until_halt("bytes", 300);
        check("bytes cycles", 32'(cycle - start), 40);
        check("bytes data count", 32'(n_data), 6);
        check("lb 0x41 be", d_be[1], 4'h4);
        check("lb 0x41 we", d_we[1], 0);
        check("sb 0x43 be", d_be[2], 4'h1);
        check("sb 0x43 wdata", d_wd[2], 32'hFFFF_FFFF);
        check("lb 0x43 be", d_be[3], 4'h1);
        check("r4 lb 0x41", mem[32], 32'h0000_0034);
        check("r5 lb 0x43", mem[33], 32'hFFFF_FFFF);
        check("word 0x40", mem[16], 32'h1234_56FF);

        // Branches: bne not taken, beq tight loop
        prog[0] = enc_i(6'h08, 0, 1, 16'd1);
        prog[1] = enc_i(6'h05, 1, 1, 16'd4);
        prog[2] = enc_i(6'h04, 0, 0, 16'hFFFF);
        load_prog(3);
        do_reset();
        k = 0;
        while (instret != 2 && k < 60) begin
            tick();
            k++;
        end
        check("bne not taken pc", inst_addr, RPC + 8);
        wait_retire(t0);
        tick();
        wait_retire(t1);
        check("beq period 1", 32'(t1 - t0), 3);
        tick();
        check("beq target", inst_addr, RPC + 8);
        wait_retire(t2);
        check("beq period 2", 32'(t2 - t1), 3);
        check("beq not halted", halted, 0);

        // Undecodable opcode
        prog[0] = 32'hFC00_0000;
        load_prog(1);
        do_reset();
        run_until_halt("op3f", 50);
        check("op3f illegal", illegal, 1);
        check("op3f retires", 32'(retire_cnt), 0);
        check("op3f instret", instret, 0);
        saw = 1'b0;
        for (int i = 0; i < 5; i++) begin
            if (mem_req !== 1'b0) saw = 1'b1;
            tick();
        end
        check("op3f req after halt", saw, 0);

        // Misaligned word load
        prog[0] = enc_i(6'h23, 0, 3, 16'h0042);
        load_prog(1);
        do_reset();
        run_until_halt("lw42", 50);
        check("lw42 illegal", illegal, 1);
        check("lw42 retires", 32'(retire_cnt), 0);
        check("lw42 data access", 32'(n_data), 0);
        saw = 1'b0;
        for (int i = 0; i < 5; i++) begin
            if (mem_req !== 1'b0) saw = 1'b1;
            tick();
        end
        check("lw42 req after halt", saw, 0);

        // Reset while a store waits in MEM
        prog[0] = enc_i(6'h08, 0, 1, 16'd7);
        prog[1] = enc_i(6'h2B, 0, 1, 16'h0080);
        load_prog(2);
        hold = 1000;
        hold_we_only = 1'b1;
        do_reset();
        k = 0;
        while (!(mem_req === 1'b1 && mem_we === 1'b1) && k < 30) begin
            tick();
            k++;
        end
        tick();
        tick();
        check("store still waiting", mem_req, 1);
        check("instret before reset", instret, 1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("mid rst mem_req", mem_req, 0);
        check("mid rst pc", inst_addr, RPC);
        check("mid rst instret", instret, 0);
        check("mid rst halted", halted, 0);
        check("mid rst illegal", illegal, 0);
        tick();
        check("refetch req", mem_req, 1);
        check("refetch addr", mem_addr, RPC);
        check("dropped store", mem[32], 32'hDEAD_BEEF);
        hold = 0;
        hold_we_only = 1'b0;

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/mips_core_mc.md
Name: mips_core_mc

Overview:
Parametrised multi-cycle successor of the single-cycle MIPS core.
- One FSM sequences fetch, decode, execute, memory and writeback over a single shared memory port with a req/ready handshake, so memory or cache latency is arbitrary.
- Adds byte loads/stores, a configurable reset vector and a retired-instruction counter.
- Sits where the single-cycle core sits; the cache or memory model attaches to the mem_* port.

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset.
- ADDR_W, 32, width of mem_addr and of the PC (4..32); upper PC bits are truncated.
- HAS_BYTE_OPS, 1, 1 = lb/sb decoded; 0 = lb/sb are illegal.
- INSTRET_W, 32, width of the instret counter.

Ports:
- clk, input, 1, rising-edge clock.
- reset, input, 1, synchronous active-high reset.
- mem_req, output, 1, memory request valid.
- mem_we, output, 1, 1 = write, 0 = read.
- mem_addr, output, ADDR_W, byte address; always word-aligned (low 2 bits 0).
- mem_be, output, 4, byte enables; bit 3 = lane 0 = bits 31:24 (big-endian).
- mem_wdata, output, 32, write data.
- mem_rdata, input, 32, read data; valid in the cycle mem_ready=1.
- mem_ready, input, 1, transfer completes in a cycle with mem_req & mem_ready.
- inst_addr, output, ADDR_W, current PC.
- halted, output, 1, sticky halt.
- illegal, output, 1, sticky; set together with halted on an undecodable instruction.
- retire, output, 1, one-cycle pulse per completed instruction.
- instret, output, INSTRET_W, count of retired instructions; wraps at 2^INSTRET_W.

Behaviour:
- Reset: synchronous and active-high, taking effect at the clock edge, including mid-transfer. Resulting state:
  - PC=RESET_PC, state=FETCH.
  - All 32 registers cleared.
  - mem_req, mem_we, halted, illegal and retire = 0; instret = 0.
- A pending transfer is abandoned on reset; the memory side must tolerate a dropped request.
- States: FETCH, DECODE, EXEC, MEM, WB, HALT.
- FETCH:
  - Drives mem_req=1, mem_we=0, mem_be=4'hF, mem_addr={PC[ADDR_W-1:2],2'b00}.
  - Stays in FETCH until mem_ready; IR is then latched from mem_rdata and the FSM goes to DECODE.
- Handshake rules:
  - While mem_req=1 waiting, addr/we/be/wdata are held stable.
  - mem_req drops the cycle after acceptance unless the next state requests again.
  - mem_ready with mem_req=0 is ignored.
- DECODE:
  - Reads rs/rt into A/B and computes PC+4.
  - syscall (op 0, funct 0x0C) -> HALT, retire pulses.
  - Illegal op/funct -> HALT with illegal=1, no retire.
  - Otherwise -> EXEC.
- EXEC:
  - Computes the ALU result into register ALUOut.
  - R-type funct: add 0x20, addu 0x21, sub 0x22, and 0x24, or 0x25, slt 0x2A (signed), sll 0x00 (shamt), jr 0x08.
  - I-type ops: addi 0x08, addiu 0x09 (sign-extended imm), andi 0x0C, ori 0x0D (zero-extended imm), lui 0x0F.
  - Arithmetic wraps mod 2^32; no overflow trap.
  - beq 0x04 / bne 0x05: PC = PC+4+(sext(imm)<<2) if taken, else PC+4; retire -> FETCH.
  - j 0x02: PC={PC+4[31:28],target,2'b00}. jal 0x03: same, and r31=PC+4. jr: PC=rs. All three retire -> FETCH.
  - lw 0x23, sw 0x2B, lb 0x20, sb 0x28 -> MEM. ALU ops -> WB.
- MEM:
  - Address is ALUOut.
  - lw/sw: be=4'hF. A word access with ALUOut[1:0]!=0 -> HALT with illegal=1.
  - sb: be = one-hot lane selected by ALUOut[1:0] (00 -> 4'b1000); wdata = rt[7:0] replicated to all lanes.
  - Waits for mem_ready, then: sw/sb retire -> FETCH; lw/lb -> WB with the data latched.
  - lb sign-extends the selected lane.
- WB:
  - Writes the rd (R-type) or rt (I-type) register; PC=PC+4; retire -> FETCH.
  - Writes to r0 are discarded; r0 always reads 0.
- Latency with zero-wait memory (mem_ready tied 1): branch/jump 3 cycles, ALU 4, store 4, load 5. Each memory wait cycle adds one cycle.
- retire:
  - Asserted for exactly one cycle at instruction completion, including syscall.
  - instret increments in that same cycle (visible next cycle).
- HALT:
  - Absorbing until reset.
  - mem_req=0; no register, PC or instret changes.

Test Plan:
- Reset to RESET_PC=0x100; mem_ready=1. Program: addi r1,r0,5; addi r2,r0,-3; add r3,r1,r2; syscall. Required: r3=2, instret=4, halted=1, first mem_addr=0x100, cycle count 4+4+4+2 with syscall retire included.
- Hold mem_ready=0 for 3 cycles on the first fetch. Required: mem_req/mem_addr stable for 4 cycles, IR latched only on the ready cycle, total latency +3.
- sw r1 (0x12345678) to 0x40, then lb r4 from 0x41. Required: second access mem_be=4'h4; r4=0x00000034. sb of 0xFF to 0x43: be=4'h1, wdata=0xFFFFFFFF. Second lb from 0x43 (lane 3 = 0xFF): r5=0xFFFFFFFF.
- beq taken with imm=-1. Required: PC returns to its own address (tight loop), 3 cycles per iteration. bne not taken: PC+4.
- Opcode 0x3F, and separately lw from 0x42. Required: halted=1, illegal=1, retire not pulsed, mem_req stays 0 thereafter.
- Assert reset during a MEM wait. Required: next cycle mem_req=0, PC=RESET_PC, instret=0, halted=0; fetch resumes the following cycle.
